div_arbiter: RTL and testbench
==============================

// Module: div_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one sequential divider (start/valid handshake) among NREQ requesters.
//  Latches the winner's operands, launches the divider, waits for completion and routes quotient/remainder/flags back.
//  Short-circuits divide-by-zero without launching the divider.
//  Optional watchdog aborts a hung divider. Sits between the requesting units and the single divider instance.
// PARAMETERS
//  NREQ     4   number of requesters (2..8); IDXW = $clog2(NREQ)
//  W        10  operand/result width
//  TIMEOUT  64  max WAIT cycles before abort (used only with DIVARB_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  sclr       in   1       reset, asynchronous, active-high
//  req        in   NREQ    per-requester request level; held until own rsp_valid
//  opA        in   NREQ*W  dividends, requester i at [i*W +: W]
//  opB        in   NREQ*W  divisors, same packing
//  gnt        out  NREQ    one-hot grant, owner of the divider
//  rsp_valid  out  NREQ    one-cycle completion pulse to owner
//  rsp_q      out  W       quotient, valid with rsp_valid
//  rsp_r      out  W       remainder, valid with rsp_valid
//  rsp_dvz    out  1       divisor was zero (q=r=0)
//  rsp_ov     out  1       divider reported overflow
//  rsp_tmo    out  1       watchdog abort (q=r=0)
//  busy       out  1       high in any state other than IDLE
//  div_start  out  1       one-cycle launch pulse to divider
//  div_A      out  W       latched dividend, stable from ISSUE through WAIT
//  div_B      out  W       latched divisor, same
//  div_sclr   out  1       divider clear: high while sclr=1, and one cycle on watchdog abort
//  div_valid  in   1       divider done pulse
//  div_q      in   W       divider quotient
//  div_r      in   W       divider remainder
//  div_ov     in   1       divider overflow, sampled with div_valid
// BEHAVIOUR
//  Reset (async): state=IDLE, ptr=0, idx=0, wait cnt=0, operand regs=0; all outputs 0 except div_sclr=1.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: if |req, winner = first set bit scanning ptr, ptr+1, ..., wrapping mod NREQ.
//    Latch idx, opA/opB slices. Next state: RESP with dvz=1 if divisor==0, else ISSUE.
//  ISSUE: div_start=1 for exactly one cycle; cnt cleared; -> WAIT.
//  WAIT: div_valid=1 -> capture div_q/div_r/div_ov -> RESP. Otherwise cnt++.
//  RESP: rsp_valid[idx]=1 with rsp_q/r/dvz/ov/tmo for one cycle; ptr <= (idx+1) mod NREQ; -> IDLE.
//  gnt[idx] high from the cycle after the arbitration edge through RESP inclusive; gnt=0 in IDLE.
//  Flags (rsp_dvz/ov/tmo) mutually exclusive; response data registered and held until the next RESP.
//  Latency, arbitration edge t:
//    normal: div_start in cycle t+1; if div_valid in cycle w, rsp_valid in w+1.
//    dvz: rsp_valid in t+1.
//  Min back-to-back gap: new arbitration in the cycle after RESP. Requester still asserting req is re-eligible, but ptr already rotated past it.
//  req deassert after grant: ignored, operation completes and response still issued.
//  req changes during non-IDLE: no effect.
//  div_valid outside WAIT: ignored.
//  div_valid on the same cycle the watchdog fires: div_valid wins, no abort.
//  sclr mid-operation: immediate return to reset values; the in-flight result is discarded, no rsp_valid.
// CONFIGURATION
//  DIVARB_TIMEOUT_EN defined: in WAIT, when cnt==TIMEOUT-1 with no div_valid:
//    div_sclr=1 that cycle; -> RESP with rsp_tmo=1, q=r=0.
//  DIVARB_TIMEOUT_EN undefined: no counter logic; WAIT lasts until div_valid; rsp_tmo tied 0.
//    div_sclr driven only by sclr; TIMEOUT unused.
// TESTING
//  1. req=0001, A0=100, B0=7, divider valid 12 cycles after start -> gnt=0001, one div_start; rsp_valid=0001, q=14, r=2, flags 0.
//  2. req=1111 held, all B!=0 -> grant order 0,1,2,3,0; one rsp_valid per op; never two gnt bits set.
//  3. req=0100, B2=0 -> rsp_valid=0100 one cycle after arbitration, rsp_dvz=1, q=r=0, div_start never asserted.
//  4. div_valid with div_ov=1 -> rsp_ov=1.
//     DIVARB_TIMEOUT_EN, TIMEOUT=64, divider never valid -> div_sclr pulse at WAIT cycle 64, rsp_tmo=1.
//  5. sclr asserted mid-WAIT -> outputs zero asynchronously, div_sclr=1, no rsp_valid.
//     After release, req=0010 is served normally (ptr=0 scan).
//  6. req0 dropped after gnt -> response still delivered to 0.
//     div_valid pulse in IDLE -> ignored, no rsp_valid.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter/sequencer sharing one sequential divider
// (start/valid handshake) among NREQ requesters. Divide-by-zero requests are
// answered directly without launching the divider.
// Optional watchdog abort of a hung divider: define DIVARB_TIMEOUT_EN.
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 10,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opA,
  input  logic [NREQ*W-1:0] opB,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_q,
  output logic [W-1:0]      rsp_r,
  output logic              rsp_dvz,
  output logic              rsp_ov,
  output logic              rsp_tmo,
  output logic              busy,
  output logic              div_start,
  output logic [W-1:0]      div_A,
  output logic [W-1:0]      div_B,
  output logic              div_sclr,
  input  logic              div_valid,
  input  logic [W-1:0]      div_q,
  input  logic [W-1:0]      div_r,
  input  logic              div_ov
);

  localparam int IDXW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("div_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_r;
  logic            r_dvz;
  logic            r_ov;

  logic [IDXW-1:0] w_win;
  logic            w_any;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_bz;
  logic [NREQ-1:0] w_own;

`ifdef DIVARB_TIMEOUT_EN
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNTW-1:0] r_cnt;
  logic            r_tmo;
  logic            w_abort;

  // div_valid on the final watchdog cycle takes precedence over the abort
  assign w_abort = (r_state == S_WAIT) && !div_valid && (r_cnt == CNTW'(TIMEOUT - 1));
`endif

  // Round-robin search: first asserted request starting at r_ptr, wrapping
  always_comb begin
    int unsigned j;
    w_win = '0;
    w_any = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_any && req[j[IDXW-1:0]]) begin
        w_any = 1'b1;
        w_win = j[IDXW-1:0];
      end
    end
  end

  // Operand mux for the arbitration winner
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win == IDXW'(i)) begin
        w_a = opA[i*W +: W];
        w_b = opB[i*W +: W];
      end
    end
  end

  assign w_bz = (w_b == '0);

  // One-hot decode of the current owner
  always_comb begin
    w_own = '0;
    for (int unsigned i = 0; i < NREQ; i++) w_own[i] = (r_idx == IDXW'(i));
  end

  // FSM state register
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = w_bz ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (div_valid) w_next = S_RESP;
`ifdef DIVARB_TIMEOUT_EN
        else if (w_abort) w_next = S_RESP;
`endif
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: grant, response strobe, divider handshake
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    div_start = 1'b0;
    div_sclr  = sclr;
    case (r_state)
      S_ISSUE: begin
        gnt       = w_own;
        busy      = 1'b1;
        div_start = 1'b1;
      end
      S_WAIT: begin
        gnt  = w_own;
        busy = 1'b1;
`ifdef DIVARB_TIMEOUT_EN
        div_sclr = sclr | w_abort;
`endif
      end
      S_RESP: begin
        gnt       = w_own;
        busy      = 1'b1;
        rsp_valid = w_own;
      end
      default: ;
    endcase
  end

  // Owner/operand latching, result capture and pointer rotation
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dvz <= 1'b0;
      r_ov  <= 1'b0;
`ifdef DIVARB_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx <= w_win;
            r_a   <= w_a;
            r_b   <= w_b;
            if (w_bz) begin
              r_q   <= '0;
              r_r   <= '0;
              r_dvz <= 1'b1;
              r_ov  <= 1'b0;
`ifdef DIVARB_TIMEOUT_EN
              r_tmo <= 1'b0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (div_valid) begin
            r_q   <= div_q;
            r_r   <= div_r;
            r_dvz <= 1'b0;
            r_ov  <= div_ov;
`ifdef DIVARB_TIMEOUT_EN
            r_tmo <= 1'b0;
          end else if (w_abort) begin
            r_q   <= '0;
            r_r   <= '0;
            r_dvz <= 1'b0;
            r_ov  <= 1'b0;
            r_tmo <= 1'b1;
`endif
          end
        end
        S_RESP: r_ptr <= (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef DIVARB_TIMEOUT_EN
  // Watchdog counter: cleared at launch, counts WAIT cycles without div_valid
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr)                                r_cnt <= '0;
    else if (r_state == S_ISSUE)             r_cnt <= '0;
    else if (r_state == S_WAIT && !div_valid) r_cnt <= r_cnt + 1'b1;
  end

  assign rsp_tmo = r_tmo;
`else
  assign rsp_tmo = 1'b0;
`endif

  assign rsp_q   = r_q;
  assign rsp_r   = r_r;
  assign rsp_dvz = r_dvz;
  assign rsp_ov  = r_ov;
  assign div_A   = r_a;
  assign div_B   = r_b;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: behavioural divider responder, event
// monitor, directed scenarios plus randomized traffic against a round-robin model.
module tb_div_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 10;
  localparam int TIMEOUT = 64;

  logic              clk;
  logic              sclr;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] opA, opB;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [W-1:0]      rsp_q, rsp_r;
  logic              rsp_dvz, rsp_ov, rsp_tmo, busy, div_start, div_sclr;
  logic [W-1:0]      div_A, div_B;
  logic              div_valid;
  logic [W-1:0]      div_q, div_r;
  logic              div_ov;

  div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .sclr(sclr), .req(req), .opA(opA), .opB(opB),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_dvz(rsp_dvz), .rsp_ov(rsp_ov), .rsp_tmo(rsp_tmo), .busy(busy),
    .div_start(div_start), .div_A(div_A), .div_B(div_B), .div_sclr(div_sclr),
    .div_valid(div_valid), .div_q(div_q), .div_r(div_r), .div_ov(div_ov)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: answers div_start after rsp_lat cycles (0 = never)
  int           rsp_lat     = 5;
  bit           rsp_ovc     = 1'b0;
  bit           force_valid = 1'b0;
  int           cd          = 0;
  logic [W-1:0] la, lb;

  initial begin
    div_valid = 1'b0; div_q = '0; div_r = '0; div_ov = 1'b0;
  end

  always @(negedge clk) begin
    if (div_sclr) cd = 0;
    div_valid = 1'b0;
    div_ov    = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        div_valid = 1'b1;
        div_q     = (lb != 0) ? la / lb : '1;
        div_r     = (lb != 0) ? la % lb : la;
        div_ov    = rsp_ovc;
      end
    end
    if (force_valid) begin
      div_valid = 1'b1; div_q = 10'h155; div_r = 10'd3;
    end
    if (div_start && !div_sclr) begin
      cd = rsp_lat; la = div_A; lb = div_B;
    end
  end

  // Monitor: records responses, launches, grant sanity and watchdog clears
  typedef struct {
    int            cyc;
    logic [NREQ-1:0] mask;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          dvz, ov, tmo;
  } rsp_t;

  rsp_t rsp_log[$];
  int   n_start = 0;
  int   last_start = -1;
  int   gnt_bad = 0;
  int   last_sclr_pulse = -1;

  always @(negedge clk) begin
    if (div_start) begin
      n_start = n_start + 1;
      last_start = cyc;
    end
    if (rsp_valid != '0)
      rsp_log.push_back('{cyc, rsp_valid, rsp_q, rsp_r, rsp_dvz, rsp_ov, rsp_tmo});
    if ($countones(gnt) > 1) gnt_bad = gnt_bad + 1;
    if (div_sclr && !sclr) last_sclr_pulse = cyc;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (rsp_log.size() > 0) ok = 1'b1;
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    opA[i*W +: W] = a;
    opB[i*W +: W] = b;
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    req  = '0;
    tick();
    tick();
    sclr = 1'b0;
    tick();
    rsp_log.delete();
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
    n_tests++; if (rsp_valid !== '0 || busy !== 1'b0 || div_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: got rsp_valid=%b busy=%b start=%b expected 0", rsp_valid, busy, div_start); end
    n_tests++; if (div_sclr !== 1'b1) begin n_fail++; $display("FAIL reset_div_sclr: got %b expected 1", div_sclr); end
    n_tests++; if ({rsp_q, rsp_r, div_A, div_B} !== '0 || {rsp_dvz, rsp_ov, rsp_tmo} !== 3'b000) begin
      n_fail++; $display("FAIL reset_data: got q=%0d r=%0d A=%0d B=%0d flags=%b expected all 0",
                         rsp_q, rsp_r, div_A, div_B, {rsp_dvz, rsp_ov, rsp_tmo}); end
    tick();
    sclr = 1'b0;
    tick();
    n_tests++; if (div_sclr !== 1'b0) begin n_fail++; $display("FAIL release_div_sclr: got %b expected 0", div_sclr); end
  endtask

  task automatic test_single();
    int c0, n0; bit ok; rsp_t r;
    set_op(0, 10'd100, 10'd7);
    rsp_lat = 12; n0 = n_start; c0 = cyc;
    req = 4'b0001;
    tick();
    n_tests++; if (gnt !== 4'b0001 || div_start !== 1'b1) begin
      n_fail++; $display("FAIL single_issue: got gnt=%b start=%b expected 0001/1", gnt, div_start); end
    wait_rsp(60, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got no response expected one"); end
    else begin
      r = rsp_log.pop_front();
      req = '0;
      n_tests++; if (r.mask !== 4'b0001 || r.q !== 10'd14 || r.r !== 10'd2) begin
        n_fail++; $display("FAIL single_result: got mask=%b q=%0d r=%0d expected 0001 14 2", r.mask, r.q, r.r); end
      n_tests++; if ({r.dvz, r.ov, r.tmo} !== 3'b000) begin
        n_fail++; $display("FAIL single_flags: got %b expected 000", {r.dvz, r.ov, r.tmo}); end
      n_tests++; if (last_start != c0 + 1 || r.cyc != c0 + 14 || n_start - n0 != 1) begin
        n_fail++; $display("FAIL single_latency: got start=%0d rsp=%0d starts=%0d expected %0d %0d 1",
                           last_start, r.cyc, n_start - n0, c0 + 1, c0 + 14); end
      tick();
      n_tests++; if (rsp_valid !== '0 || rsp_q !== 10'd14 || busy !== 1'b0) begin
        n_fail++; $display("FAIL single_hold: got rsp_valid=%b q=%0d busy=%b expected 0 14 0", rsp_valid, rsp_q, busy); end
    end
  endtask

  task automatic test_round_robin();
    int n0, prev, gb0; bit ok; rsp_t r;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 10'(50 + i * 37), 10'(i + 3));
    rsp_lat = 4; n0 = n_start; prev = 0; gb0 = gnt_bad;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(40, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: op %0d got none expected response", k); break; end
      r = rsp_log.pop_front();
      if (k == 4) req = '0;
      n_tests++; if (r.mask !== 4'(1 << (k % 4)) || r.q !== 10'((50 + (k % 4) * 37) / ((k % 4) + 3))
                     || r.r !== 10'((50 + (k % 4) * 37) % ((k % 4) + 3))) begin
        n_fail++; $display("FAIL rr_order: op %0d got mask=%b q=%0d r=%0d expected mask=%b", k, r.mask, r.q, r.r, 4'(1 << (k % 4))); end
      if (k > 0) begin
        n_tests++; if (r.cyc - prev != rsp_lat + 3) begin
          n_fail++; $display("FAIL rr_gap: got %0d expected %0d", r.cyc - prev, rsp_lat + 3); end
      end
      prev = r.cyc;
    end
    tick();
    n_tests++; if (n_start - n0 != 5 || gnt_bad != gb0) begin
      n_fail++; $display("FAIL rr_counts: got starts=%0d multigrant=%0d expected 5 0", n_start - n0, gnt_bad - gb0); end
  endtask

  task automatic test_dvz();
    int c0, n0; bit ok; rsp_t r;
    set_op(2, 10'd123, 10'd0);
    n0 = n_start; c0 = cyc;
    req = 4'b0100;
    wait_rsp(20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL dvz_timeout: got none expected response"); end
    else begin
      r = rsp_log.pop_front();
      req = '0;
      n_tests++; if (r.mask !== 4'b0100 || r.cyc != c0 + 1) begin
        n_fail++; $display("FAIL dvz_timing: got mask=%b cyc=%0d expected 0100 %0d", r.mask, r.cyc, c0 + 1); end
      n_tests++; if ({r.dvz, r.ov, r.tmo} !== 3'b100 || r.q !== '0 || r.r !== '0) begin
        n_fail++; $display("FAIL dvz_result: got flags=%b q=%0d r=%0d expected 100 0 0", {r.dvz, r.ov, r.tmo}, r.q, r.r); end
      tick();
      n_tests++; if (n_start != n0) begin n_fail++; $display("FAIL dvz_no_start: got %0d starts expected 0", n_start - n0); end
    end
  endtask

  task automatic test_overflow();
    bit ok; rsp_t r;
    set_op(1, 10'd999, 10'd1);
    rsp_lat = 6; rsp_ovc = 1'b1;
    req = 4'b0010;
    wait_rsp(40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ov_timeout: got none expected response"); end
    else begin
      r = rsp_log.pop_front();
      req = '0;
      n_tests++; if ({r.dvz, r.ov, r.tmo} !== 3'b010 || r.q !== 10'd999 || r.r !== '0 || r.mask !== 4'b0010) begin
        n_fail++; $display("FAIL ov_result: got flags=%b q=%0d r=%0d mask=%b expected 010 999 0 0010",
                           {r.dvz, r.ov, r.tmo}, r.q, r.r, r.mask); end
    end
    rsp_ovc = 1'b0;
    tick();
  endtask

`ifdef DIVARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; rsp_t r;
    set_op(3, 10'd300, 10'd4);
    rsp_lat = 0; last_sclr_pulse = -1;
    req = 4'b1000;
    wait_rsp(TIMEOUT + 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_none: got no response expected abort"); end
    else begin
      r = rsp_log.pop_front();
      req = '0;
      n_tests++; if (last_sclr_pulse != last_start + TIMEOUT || r.cyc != last_start + TIMEOUT + 1) begin
        n_fail++; $display("FAIL tmo_timing: got clr=%0d rsp=%0d expected %0d %0d",
                           last_sclr_pulse, r.cyc, last_start + TIMEOUT, last_start + TIMEOUT + 1); end
      n_tests++; if ({r.dvz, r.ov, r.tmo} !== 3'b001 || r.q !== '0 || r.r !== '0) begin
        n_fail++; $display("FAIL tmo_result: got flags=%b q=%0d r=%0d expected 001 0 0", {r.dvz, r.ov, r.tmo}, r.q, r.r); end
    end
    tick();
    // valid arriving on the last watchdog cycle must win over the abort
    rsp_lat = TIMEOUT; last_sclr_pulse = -1;
    req = 4'b1000;
    wait_rsp(TIMEOUT + 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_race_none: got no response expected one"); end
    else begin
      r = rsp_log.pop_front();
      req = '0;
      n_tests++; if (r.tmo !== 1'b0 || r.q !== 10'd75 || last_sclr_pulse != -1) begin
        n_fail++; $display("FAIL tmo_race: got tmo=%b q=%0d clr=%0d expected 0 75 -1", r.tmo, r.q, last_sclr_pulse); end
    end
    rsp_lat = 5;
    tick();
  endtask
`else
  task automatic test_long_wait();
    bit ok; rsp_t r;
    set_op(3, 10'd300, 10'd4);
    rsp_lat = TIMEOUT + 10;
    req = 4'b1000;
    wait_rsp(TIMEOUT + 40, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL long_none: got no response expected one"); end
    else begin
      r = rsp_log.pop_front();
      req = '0;
      n_tests++; if (r.tmo !== 1'b0 || r.q !== 10'd75 || r.mask !== 4'b1000) begin
        n_fail++; $display("FAIL long_result: got tmo=%b q=%0d mask=%b expected 0 75 1000", r.tmo, r.q, r.mask); end
    end
    rsp_lat = 5;
    tick();
  endtask
`endif

  task automatic test_sclr_mid();
    int n0; bit ok; rsp_t r;
    do_reset();
    set_op(1, 10'd77, 10'd5);
    rsp_lat = 3;
    req = 4'b0010;
    wait_rsp(30, ok);
    rsp_log.delete();
    req = '0;
    tick();
    set_op(2, 10'd500, 10'd9);
    rsp_lat = 30;
    req = 4'b0100;
    for (int i = 0; i < 6; i++) tick();
    sclr = 1'b1;
    req  = '0;
    #1;
    n_tests++; if (gnt !== '0 || busy !== 1'b0 || div_sclr !== 1'b1) begin
      n_fail++; $display("FAIL sclr_async: got gnt=%b busy=%b div_sclr=%b expected 0 0 1", gnt, busy, div_sclr); end
    n_tests++; if (rsp_q !== '0 || rsp_r !== '0 || div_A !== '0) begin
      n_fail++; $display("FAIL sclr_data: got q=%0d r=%0d A=%0d expected 0", rsp_q, rsp_r, div_A); end
    tick();
    tick();
    sclr = 1'b0;
    n0 = n_start;
    for (int i = 0; i < 40; i++) tick();
    n_tests++; if (rsp_log.size() != 0 || n_start != n0) begin
      n_fail++; $display("FAIL sclr_discard: got %0d responses %0d starts expected 0 0", rsp_log.size(), n_start - n0); end
    rsp_log.delete();
    // with ptr back at 0, requester 1 wins over 3 (a stale ptr of 2 would pick 3)
    set_op(1, 10'd77, 10'd5);
    set_op(3, 10'd40, 10'd6);
    rsp_lat = 4;
    req = 4'b1010;
    wait_rsp(30, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL sclr_after_none: got none expected response"); end
    else begin
      r = rsp_log.pop_front();
      req = '0;
      n_tests++; if (r.mask !== 4'b0010 || r.q !== 10'd15 || r.r !== 10'd2) begin
        n_fail++; $display("FAIL sclr_after: got mask=%b q=%0d r=%0d expected 0010 15 2", r.mask, r.q, r.r); end
    end
    tick();
  endtask

  task automatic test_req_drop();
    bit ok; rsp_t r;
    do_reset();
    set_op(0, 10'd1000, 10'd33);
    rsp_lat = 8;
    req = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    req = '0;
    wait_rsp(30, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL drop_none: got none expected response"); end
    else begin
      r = rsp_log.pop_front();
      n_tests++; if (r.mask !== 4'b0001 || r.q !== 10'd30 || r.r !== 10'd10) begin
        n_fail++; $display("FAIL drop_result: got mask=%b q=%0d r=%0d expected 0001 30 10", r.mask, r.q, r.r); end
    end
    for (int i = 0; i < 10; i++) tick();
    n_tests++; if (rsp_log.size() != 0) begin n_fail++; $display("FAIL drop_extra: got %0d responses expected 0", rsp_log.size()); end
  endtask

  task automatic test_idle_valid();
    logic [W-1:0] held;
    rsp_log.delete();
    held = rsp_q;
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (rsp_log.size() != 0 || busy !== 1'b0 || rsp_q !== held) begin
      n_fail++; $display("FAIL idle_valid: got rsp=%0d busy=%b q=%0d expected 0 0 %0d", rsp_log.size(), busy, rsp_q, held); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend, nb;
    logic [W-1:0] ma [NREQ];
    logic [W-1:0] mb [NREQ];
    int m_ptr, win; bit ok, ovx; rsp_t r;
    logic [W-1:0] eq, er;
    do_reset();
    m_ptr = 0; pend = '0;
    for (int op = 0; op < 40; op++) begin
      nb = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~pend;
      if ((pend | nb) == '0) nb = NREQ'(1 << $urandom_range(0, NREQ - 1));
      for (int i = 0; i < NREQ; i++) begin
        if (nb[i]) begin
          ma[i] = W'($urandom_range(0, (1 << W) - 1));
          mb[i] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 40));
          set_op(i, ma[i], mb[i]);
        end
      end
      pend = pend | nb;
      rsp_lat = $urandom_range(1, 20);
      ovx = ($urandom_range(0, 3) == 0);
      rsp_ovc = ovx;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j = (m_ptr + k) % NREQ;
        if (win < 0 && pend[j]) win = j;
      end
      req = pend;
      wait_rsp(60, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: op %0d got none expected response", op); break; end
      r = rsp_log.pop_front();
      eq = (mb[win] != 0) ? ma[win] / mb[win] : '0;
      er = (mb[win] != 0) ? ma[win] % mb[win] : '0;
      n_tests++; if (r.mask !== NREQ'(1 << win) || r.q !== eq || r.r !== er ||
                     {r.dvz, r.ov, r.tmo} !== {mb[win] == 0, (mb[win] != 0) && ovx, 1'b0}) begin
        n_fail++; $display("FAIL rand_op%0d: got mask=%b q=%0d r=%0d flags=%b expected mask=%b q=%0d r=%0d flags=%b",
                           op, r.mask, r.q, r.r, {r.dvz, r.ov, r.tmo}, NREQ'(1 << win), eq, er,
                           {mb[win] == 0, (mb[win] != 0) && ovx, 1'b0}); end
      pend[win] = 1'b0;
      m_ptr = (win + 1) % NREQ;
      req = pend;
    end
    req = '0;
    rsp_ovc = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    sclr = 1'b1; req = '0; opA = '0; opB = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_dvz();
    test_overflow();
`ifdef DIVARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_sclr_mid();
    test_req_drop();
    test_idle_valid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got no completion expected finish");
    $fatal(1);
  end

endmodule
